// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: frame-level sequencer for a window_slider.
// Launches the slider, requests windows one at a time, registers each
// returned window and offers it to the PE array over valid/ready, tagged
// with its output-map row/column.
// Optional build macro: CONV_SCHED_PERF_CNT_EN adds the stall_cycles counter.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for cfg_start
// S_LAUNCH | sl_start pulse to the slider
// S_REQ    | sl_next pulse, one window requested
// S_WAIT   | waiting for sl_valid (or an early sl_done)
// S_ISSUE  | window held on pe_* until pe_ready
// S_DONE   | frame_done pulse, then back to idle
module conv_window_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_H      = 4,
  parameter int IMG_W      = 4,
  parameter int K_H        = 2,
  parameter int K_W        = 2,
  parameter int STRIDE_H   = 1,
  parameter int STRIDE_W   = 1,
  localparam int OUT_H = (IMG_H - K_H) / STRIDE_H + 1,
  localparam int OUT_W = (IMG_W - K_W) / STRIDE_W + 1,
  localparam int N_WIN = OUT_H * OUT_W,
  localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1,
  localparam int NW    = ($clog2(N_WIN + 1) > 1) ? $clog2(N_WIN + 1) : 1,
  localparam int WIN_W = DATA_WIDTH * K_H * K_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  output logic             busy,
  output logic             frame_done,
  output logic             err,
  output logic             sl_start,
  output logic             sl_next,
  input  logic [WIN_W-1:0] sl_window,
  input  logic             sl_valid,
  input  logic             sl_done,
  output logic             pe_valid,
  input  logic             pe_ready,
  output logic [WIN_W-1:0] pe_window,
  output logic [RW-1:0]    pe_row,
  output logic [CW-1:0]    pe_col,
  output logic             pe_last
`ifdef CONV_SCHED_PERF_CNT_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_REQ, S_WAIT, S_ISSUE, S_DONE
  } state_t;

  state_t         state;
  logic [NW-1:0]  issued;
  logic [RW-1:0]  row;
  logic [CW-1:0]  col;
  logic           last_win;

  // The window currently held is the final one of the frame.
  assign last_win = (issued == NW'(N_WIN - 1));
  assign pe_last  = pe_valid & last_win;
  assign pe_row   = row;
  assign pe_col   = col;

  // Frame sequencer: state, window/coordinate counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      sl_start   <= 1'b0;
      sl_next    <= 1'b0;
      pe_valid   <= 1'b0;
      pe_window  <= '0;
      issued     <= '0;
      row        <= '0;
      col        <= '0;
    end else begin
      sl_start   <= 1'b0;
      sl_next    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            state    <= S_LAUNCH;
            busy     <= 1'b1;
            sl_start <= 1'b1;
            err      <= 1'b0;
            issued   <= '0;
            row      <= '0;
            col      <= '0;
          end
        end
        S_LAUNCH: begin
          state   <= S_REQ;
          sl_next <= 1'b1;
        end
        S_REQ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A valid window wins over a simultaneous done.
          if (sl_valid) begin
            pe_window <= sl_window;
            pe_valid  <= 1'b1;
            state     <= S_ISSUE;
          end else if (sl_done && (issued < NW'(N_WIN))) begin
            err        <= 1'b1;
            frame_done <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_ISSUE: begin
          if (pe_ready) begin
            pe_valid <= 1'b0;
            issued   <= issued + 1'b1;
            if (col == CW'(OUT_W - 1)) begin
              col <= '0;
              row <= (row == RW'(OUT_H - 1)) ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (last_win) begin
              frame_done <= 1'b1;
              state      <= S_DONE;
            end else begin
              sl_next <= 1'b1;
              state   <= S_REQ;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy     <= 1'b0;
          pe_valid <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CONV_SCHED_PERF_CNT_EN
  // Saturating count of cycles the PE leaves an offered window waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if ((state == S_IDLE) && cfg_start) begin
      stall_cycles <= '0;
    end else if (pe_valid && !pe_ready && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler: a behavioural slider, a table of frame
// scenarios, and a monitor comparing every handshake against window
// contents computed directly from the image and the output coordinate.
module tb_conv_window_scheduler;
  localparam int DW    = 8;
  localparam int IMG_H = 4;
  localparam int IMG_W = 4;
  localparam int K_H   = 2;
  localparam int K_W   = 2;
  localparam int S_H   = 1;
  localparam int S_W   = 1;
  localparam int OUT_H = (IMG_H - K_H) / S_H + 1;
  localparam int OUT_W = (IMG_W - K_W) / S_W + 1;
  localparam int N_WIN = OUT_H * OUT_W;
  localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int WIN_W = DW * K_H * K_W;

  logic             clk, rst, cfg_start;
  logic             busy, frame_done, err, sl_start, sl_next;
  logic [WIN_W-1:0] sl_window;
  logic             sl_valid, sl_done;
  logic             pe_valid, pe_ready, pe_last;
  logic [WIN_W-1:0] pe_window;
  logic [RW-1:0]    pe_row;
  logic [CW-1:0]    pe_col;
`ifdef CONV_SCHED_PERF_CNT_EN
  logic [15:0]      stall_cycles;
`endif

  conv_window_scheduler #(
    .DATA_WIDTH(DW), .IMG_H(IMG_H), .IMG_W(IMG_W), .K_H(K_H), .K_W(K_W),
    .STRIDE_H(S_H), .STRIDE_W(S_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .busy(busy),
    .frame_done(frame_done), .err(err), .sl_start(sl_start), .sl_next(sl_next),
    .sl_window(sl_window), .sl_valid(sl_valid), .sl_done(sl_done),
    .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_window(pe_window),
    .pe_row(pe_row), .pe_col(pe_col), .pe_last(pe_last)
`ifdef CONV_SCHED_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference image and window extraction from coordinates.
  logic [DW-1:0] img [IMG_H][IMG_W];
  bit fixed_img;

  function automatic logic [WIN_W-1:0] exp_window(input int n);
    logic [WIN_W-1:0] w;
    int r0, c0;
    w  = '0;
    r0 = (n / OUT_W) * S_H;
    c0 = (n % OUT_W) * S_W;
    for (int kr = 0; kr < K_H; kr++)
      for (int kc = 0; kc < K_W; kc++)
        w[(kr*K_W+kc)*DW +: DW] = img[r0+kr][c0+kc];
    return w;
  endfunction

  // Behavioural slider: answers each sl_next after 1..sl_lat_max cycles.
  int sl_lat_max = 1;
  int early_n    = -1;
  bit done_last  = 1'b0;
  int s_cnt      = 0;
  int s_win      = 0;

  initial begin
    sl_valid  = 1'b0;
    sl_done   = 1'b0;
    sl_window = '0;
    forever begin
      @(posedge clk); #1;
      sl_valid = 1'b0;
      sl_done  = 1'b0;
      if (s_cnt > 0) begin
        s_cnt--;
        if (s_cnt == 0) begin
          if (early_n >= 0 && s_win == early_n) begin
            sl_done = 1'b1;
          end else begin
            sl_valid  = 1'b1;
            sl_window = exp_window(s_win);
            if (done_last && s_win == N_WIN - 1) sl_done = 1'b1;
            s_win++;
          end
        end
      end
      if (sl_start) begin
        s_win = 0;
        s_cnt = 0;
      end
      if (sl_next) s_cnt = (sl_lat_max > 1) ? int'($urandom_range(1, sl_lat_max)) : 1;
    end
  end

  // Monitor: handshake contents, hold-while-stalled, request discipline.
  bit               mon_en = 1'b0;
  int               hs_base = 0;
  int               hs_total = 0;
  int               start_total = 0;
  int               stall_total = 0;
  int               done_total = 0;
  int               last_hs_cyc = 0;
  int               done_cyc = 0;
  bit               prev_stall = 1'b0;
  logic [WIN_W-1:0] prev_win;
  logic [RW-1:0]    prev_row;
  logic [CW-1:0]    prev_col;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        int idx;
        idx = hs_total - hs_base;
        if (sl_start) start_total++;
        if (sl_next) chk("sl_next_while_pending", 64'(pe_valid), 64'd0);
        if (prev_stall) begin
          chk("stall_hold_valid", 64'(pe_valid), 64'd1);
          chk("stall_hold_window", 64'(pe_window), 64'(prev_win));
          chk("stall_hold_coord", 64'({pe_row, pe_col}), 64'({prev_row, prev_col}));
        end
        if (pe_valid && pe_ready) begin
          chk("pe_row", 64'(pe_row), 64'(idx / OUT_W));
          chk("pe_col", 64'(pe_col), 64'(idx % OUT_W));
          chk("pe_window", 64'(pe_window), 64'(exp_window(idx)));
          chk("pe_last", 64'(pe_last), 64'(idx == N_WIN - 1));
          if (fixed_img && idx == 0) chk("first_window", 64'(pe_window), 64'h06050201);
          if (fixed_img && idx == N_WIN - 1) chk("last_window", 64'(pe_window), 64'h100F0C0B);
          hs_total++;
          last_hs_cyc = cyc;
        end
        if (pe_valid && !pe_ready) stall_total++;
        prev_stall = pe_valid && !pe_ready;
        prev_win   = pe_window;
        prev_row   = pe_row;
        prev_col   = pe_col;
        if (frame_done) begin
          chk("busy_at_done", 64'(busy), 64'd1);
          done_total++;
          done_cyc = cyc;
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  typedef struct {
    int ready_mode;   // 0 always ready, 1 five-cycle stall on window 4, 2 random
    int lat_max;
    int early;
    bit dlast;
    bit glitch;
    bit fixed;
    int exp_hs;
    bit exp_err;
    int exp_stall;    // -1: use the bench's own stall tally
  } scen_t;

  task automatic load_image(input bit fixed);
    fixed_img = fixed;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = fixed ? DW'(r * IMG_W + c + 1) : DW'($urandom);
  endtask

  task automatic run_frame(input scen_t s, input string tag);
    int t, stall_left, g, st_base, stl_base, dn_base;
    bit saw_next;
    sl_lat_max = s.lat_max;
    early_n    = s.early;
    done_last  = s.dlast;
    load_image(s.fixed);
    hs_base  = hs_total;
    st_base  = start_total;
    stl_base = stall_total;
    dn_base  = done_total;
    mon_en   = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b1;
    pe_ready  = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    chk({tag, " launch_busy"}, 64'(busy), 64'd1);
    chk({tag, " launch_err_clear"}, 64'(err), 64'd0);
    chk({tag, " launch_sl_start"}, 64'(sl_start), 64'd1);
    t = 0; stall_left = 5; g = 0; saw_next = 1'b0;
    while (done_total == dn_base && t < 400) begin
      @(posedge clk); #1;
      t++;
      cfg_start = 1'b0;
      case (s.ready_mode)
        1: begin
          if (pe_valid && (hs_total - hs_base) == 3 && stall_left > 0) begin
            pe_ready = 1'b0;
            stall_left--;
          end else begin
            pe_ready = 1'b1;
          end
        end
        2: pe_ready = ($urandom_range(0, 3) != 0);
        default: pe_ready = 1'b1;
      endcase
      if (s.glitch && g == 0 && pe_valid && (hs_total - hs_base) == 2) begin
        cfg_start = 1'b1;
        g = 1;
      end else if (s.glitch && g == 1 && saw_next && (hs_total - hs_base) == 5) begin
        cfg_start = 1'b1;
        g = 2;
      end
      saw_next = sl_next;
    end
    cfg_start = 1'b0;
    pe_ready  = 1'b1;
    if (done_total == dn_base) chk({tag, " frame_done_timeout"}, 64'd0, 64'd1);
    chk({tag, " busy_after_done"}, 64'(busy), 64'd0);
    chk({tag, " single_done_pulse"}, 64'(frame_done), 64'd0);
    chk({tag, " handshakes"}, 64'(hs_total - hs_base), 64'(s.exp_hs));
    chk({tag, " err"}, 64'(err), 64'(s.exp_err));
    chk({tag, " sl_start_count"}, 64'(start_total - st_base), 64'd1);
    if (!s.exp_err) chk({tag, " done_latency"}, 64'(done_cyc - last_hs_cyc), 64'd1);
`ifdef CONV_SCHED_PERF_CNT_EN
    chk({tag, " stall_cycles"}, 64'(stall_cycles),
        64'((s.exp_stall >= 0) ? s.exp_stall : stall_total - stl_base));
`endif
  endtask

  scen_t tbl [8];

  initial begin
    int t;
    tbl[0] = '{0, 1, -1, 1'b0, 1'b0, 1'b1, 9, 1'b0, 0};
    tbl[1] = '{1, 1, -1, 1'b0, 1'b0, 1'b1, 9, 1'b0, 5};
    tbl[2] = '{0, 1,  4, 1'b0, 1'b0, 1'b1, 4, 1'b1, 0};
    tbl[3] = '{0, 1, -1, 1'b0, 1'b1, 1'b0, 9, 1'b0, 0};
    tbl[4] = '{0, 1, -1, 1'b1, 1'b0, 1'b0, 9, 1'b0, 0};
    tbl[5] = '{2, 3, -1, 1'b0, 1'b0, 1'b0, 9, 1'b0, -1};
    tbl[6] = '{2, 4, -1, 1'b0, 1'b0, 1'b0, 9, 1'b0, -1};
    tbl[7] = '{2, 2,  7, 1'b0, 1'b0, 1'b0, 7, 1'b1, -1};

    rst = 1'b0; cfg_start = 1'b0; pe_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_pe_valid", 64'(pe_valid), 64'd0);
    chk("reset_outputs", 64'({frame_done, err, sl_start, sl_next, pe_last}), 64'd0);
    chk("reset_coord", 64'({pe_row, pe_col}), 64'd0);
    chk("reset_window", 64'(pe_window), 64'd0);
    #2 rst = 1'b1;

    for (int i = 0; i < 8; i++) run_frame(tbl[i], $sformatf("scen%0d", i));

    // Asynchronous reset while window 5 is offered and stalled.
    sl_lat_max = 1; early_n = -1; done_last = 1'b0;
    load_image(1'b0);
    hs_base = hs_total;
    mon_en  = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    t = 0;
    while (!(pe_valid && (hs_total - hs_base) == 4) && t < 200) begin
      @(posedge clk); #1;
      t++;
      pe_ready = 1'b1;
    end
    if (t >= 200) chk("rst_test_reach_window5", 64'd0, 64'd1);
    pe_ready = 1'b0;
    chk("pre_reset_coord", 64'({pe_row, pe_col}), 64'({2'd1, 2'd1}));
    mon_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_pe_valid", 64'(pe_valid), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_frame_done", 64'(frame_done), 64'd0);
    chk("async_rst_coord", 64'({pe_row, pe_col, pe_last}), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    pe_ready = 1'b1;
    run_frame(tbl[0], "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
